// File: rtl/alu_operand_sequencer.sv
// Collects A, B, opcode as byte beats, drives registered operands to a comb ALU, returns the registered result.
// Latency: opcode beat accepted in cycle N, out_valid in cycle N+2; min period 5 cycles (4 with ACCUM_CHAIN_EN chaining).
// Backpressure: in_ready low while a result is pending; one result held until out_ready. Optional macro: ACCUM_CHAIN_EN.
module alu_operand_sequencer #(
  parameter int WIDTH = 8,
  parameter int OP_W  = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] done_count
);

  typedef enum logic [2:0] {S_A, S_B, S_OP, S_EXEC, S_OUT} state_t;

  state_t state_q, state_d;
  logic   beat_acc;
  logic   out_hs;

  assign beat_acc = in_valid & in_ready;
  // Abort does not suppress a result handshake that lands in the same cycle.
  assign out_hs   = (state_q == S_OUT) & out_valid & out_ready;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = (state_q != S_A);
    unique case (state_q)
      S_A: begin
        in_ready = ~abort;
        if (beat_acc) state_d = S_B;
      end
      S_B: begin
        in_ready = ~abort;
        if (beat_acc) state_d = S_OP;
      end
      S_OP: begin
        in_ready = ~abort;
        if (beat_acc) state_d = S_EXEC;
      end
      S_EXEC: state_d = S_OUT;
      S_OUT: begin
`ifdef ACCUM_CHAIN_EN
        if (out_ready) state_d = S_B;
`else
        if (out_ready) state_d = S_A;
`endif
      end
      default: state_d = S_A;
    endcase
    if (abort) state_d = S_A;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_A;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      done_count <= '0;
    end else begin
      state_q <= state_d;
      if (beat_acc) begin
        unique case (state_q)
          S_A:     alu_a  <= in_data;
          S_B:     alu_b  <= in_data;
          S_OP:    alu_op <= in_data[OP_W-1:0];
          default: ;
        endcase
      end
      if ((state_q == S_EXEC) && !abort) begin
        out_data  <= alu_result;
        out_valid <= 1'b1;
      end
      if (out_hs) begin
        out_valid  <= 1'b0;
        done_count <= done_count + CNT_W'(1);
`ifdef ACCUM_CHAIN_EN
        // Previous result becomes operand A unless the chain is being cancelled.
        if (!abort) alu_a <= out_data;
`endif
      end
      if (abort) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: bench-side ALU, expected-result queue, per-scenario tasks.
module tb_alu_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, abort, out_valid, out_ready, busy;
  logic [7:0] in_data, alu_a, alu_b, alu_result, out_data, done_count;
  logic [2:0] alu_op;

  int         checks = 0;
  int         passed = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_done = 8'd0;
  logic [7:0] last_result = 8'd0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return a << 1;
      default: return b;
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_op);

  alu_operand_sequencer #(.WIDTH(8), .OP_W(3), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .abort(abort), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .done_count(done_count)
  );

  task automatic beat(input logic [7:0] d);
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL beat_in_ready: got %b want 1 (data %h)", in_ready, d); else passed++;
    @(posedge clk);
  endtask

  task automatic go_idle();
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic load3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
`ifdef ACCUM_CHAIN_EN
    if (busy) go_idle();
`endif
    beat(a);
    beat(b);
    beat(op);
    exp_q.push_back(alu_f(a, b, op[2:0]));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load2(input logic [7:0] b, input logic [7:0] op);
    beat(b);
    beat(op);
    exp_q.push_back(alu_f(last_result, b, op[2:0]));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Waits for a result, checks it against the queue head, then completes the handshake.
  task automatic collect(output int waited, output logic [7:0] got);
    logic [7:0] e;
    waited = 0;
    got    = 8'hxx;
    @(negedge clk);
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!out_valid || exp_q.size() == 0) begin
      $display("FAIL collect_timeout: out_valid=%b queued=%0d", out_valid, exp_q.size());
      return;
    end
    passed++;
    e   = exp_q.pop_front();
    got = out_data;
    checks++; if (out_data !== e) $display("FAIL result_data: got %h want %h", out_data, e); else passed++;
    out_ready = 1'b1;
    @(posedge clk);
    exp_done++;
    last_result = e;
    @(negedge clk);
    checks++; if (done_count !== exp_done) $display("FAIL done_count: got %0d want %0d", done_count, exp_done); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL valid_after_hs: got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1)   $display("FAIL rst_in_ready: got %b want 1", in_ready); else passed++;
    checks++; if (busy !== 1'b0)       $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    checks++; if (out_valid !== 1'b0)  $display("FAIL rst_out_valid: got %b want 0", out_valid); else passed++;
    checks++; if (out_data !== 8'h00)  $display("FAIL rst_out_data: got %h want 00", out_data); else passed++;
    checks++; if ({alu_a, alu_b, alu_op} !== 19'h0) $display("FAIL rst_operands: got %h/%h/%h want 0", alu_a, alu_b, alu_op); else passed++;
    checks++; if (done_count !== 8'd0) $display("FAIL rst_done_count: got %0d want 0", done_count); else passed++;
  endtask

  task automatic test_basic();
    int w; logic [7:0] g;
    load3(8'h05, 8'h03, 8'h00);
    checks++; if (out_valid !== 1'b0) $display("FAIL exec_valid: got %b want 0", out_valid); else passed++;
    checks++; if (busy !== 1'b1)      $display("FAIL exec_busy: got %b want 1", busy); else passed++;
    checks++; if (in_ready !== 1'b0)  $display("FAIL exec_in_ready: got %b want 0", in_ready); else passed++;
    checks++; if ({alu_a, alu_b} !== 16'h0503) $display("FAIL operands_held: got %h%h want 0503", alu_a, alu_b); else passed++;
    collect(w, g);
    checks++; if (w !== 0)      $display("FAIL basic_latency: got %0d extra cycles want 0", w); else passed++;
    checks++; if (g !== 8'h08)  $display("FAIL basic_value: got %h want 08", g); else passed++;
`ifndef ACCUM_CHAIN_EN
    checks++; if (busy !== 1'b0) $display("FAIL basic_idle: got busy %b want 0", busy); else passed++;
`endif
  endtask

  task automatic test_upper_bits();
    int w; logic [7:0] g;
    load3(8'h03, 8'h05, 8'hF9);
    checks++; if (alu_op !== 3'd1) $display("FAIL op_upper_bits: got %0d want 1", alu_op); else passed++;
    collect(w, g);
    checks++; if (g !== 8'hFE) $display("FAIL sub_value: got %h want fe", g); else passed++;
  endtask

  task automatic test_hold();
    int w; logic [7:0] g;
    out_ready = 1'b0;
    load3(8'hF0, 8'h0F, 8'h04);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) $display("FAIL hold_valid[%0d]: got %b want 1", i, out_valid); else passed++;
      checks++; if (out_data !== 8'hFF) $display("FAIL hold_data[%0d]: got %h want ff", i, out_data); else passed++;
      checks++; if (in_ready !== 1'b0)  $display("FAIL hold_in_ready[%0d]: got %b want 0", i, in_ready); else passed++;
      checks++; if (done_count !== exp_done) $display("FAIL hold_count[%0d]: got %0d want %0d", i, done_count, exp_done); else passed++;
    end
    collect(w, g);
  endtask

  task automatic test_abort();
    int w; logic [7:0] g;
    go_idle();
    beat(8'hAA);
    @(negedge clk);
    in_data  = 8'hBB;
    abort    = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) $display("FAIL abort_in_ready: got %b want 0", in_ready); else passed++;
    @(posedge clk);
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;
    checks++; if (busy !== 1'b0)    $display("FAIL abort_state: got busy %b want 0", busy); else passed++;
    checks++; if (alu_a !== 8'hAA)  $display("FAIL abort_keep_a: got %h want aa", alu_a); else passed++;
    checks++; if (alu_b !== 8'h0F)  $display("FAIL abort_keep_b: got %h want 0f", alu_b); else passed++;
    load3(8'h01, 8'h02, 8'h00);
    collect(w, g);
    checks++; if (g !== 8'h03) $display("FAIL post_abort_value: got %h want 03", g); else passed++;
  endtask

  task automatic test_abort_handshake();
    logic [7:0] e;
    go_idle();
    out_ready = 1'b0;
    load3(8'h21, 8'h12, 8'h00);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (out_valid !== 1'b1 || out_data !== e) $display("FAIL abort_hs_data: got %b/%h want 1/%h", out_valid, out_data, e); else passed++;
    abort     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    exp_done++;
    last_result = e;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (done_count !== exp_done) $display("FAIL abort_hs_count: got %0d want %0d", done_count, exp_done); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL abort_hs_valid: got %b want 0", out_valid); else passed++;
    checks++; if (busy !== 1'b0)      $display("FAIL abort_hs_state: got busy %b want 0", busy); else passed++;
    checks++; if (alu_a !== 8'h21)    $display("FAIL abort_hs_keep_a: got %h want 21", alu_a); else passed++;
  endtask

  task automatic test_reset_mid();
    int w; logic [7:0] g;
    go_idle();
    beat(8'h11);
    beat(8'h22);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    test_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_done = 8'd0;
    last_result = 8'd0;
    exp_q.delete();
    load3(8'h07, 8'h02, 8'h01);
    collect(w, g);
    checks++; if (g !== 8'h05) $display("FAIL post_reset_value: got %h want 05", g); else passed++;
  endtask

`ifdef ACCUM_CHAIN_EN
  task automatic test_accum();
    int w; logic [7:0] g;
    load3(8'h10, 8'h01, 8'h00);
    collect(w, g);
    checks++; if (g !== 8'h11)   $display("FAIL accum_first: got %h want 11", g); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL accum_chain_state: got busy %b want 1", busy); else passed++;
    checks++; if (alu_a !== 8'h11) $display("FAIL accum_chain_a: got %h want 11", alu_a); else passed++;
    load2(8'h01, 8'h00);
    collect(w, g);
    checks++; if (g !== 8'h12) $display("FAIL accum_second: got %h want 12", g); else passed++;
  endtask
`endif

  task automatic test_wrap();
    int w; int n; logic [7:0] g;
    n = 256 - int'(exp_done);
    for (int i = 0; i < n; i++) begin
`ifdef ACCUM_CHAIN_EN
      load2(8'($urandom), 8'($urandom_range(0, 7)));
`else
      load3(8'($urandom), 8'($urandom), 8'($urandom_range(0, 255)));
`endif
      collect(w, g);
    end
    checks++; if (done_count !== 8'd0) $display("FAIL count_wrap: got %0d want 0", done_count); else passed++;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    abort     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_upper_bits();
    test_hold();
    test_abort();
    test_abort_handshake();
    test_reset_mid();
`ifdef ACCUM_CHAIN_EN
    test_accum();
`endif
    test_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
